program_counter_ctrl: RTL and testbench

- Sequences the core's program counter. Holds the architectural PC register and computes the sequential next PC as PC+4.
- Runs the fetch handshake with instruction memory. Selects the next PC from sequential, branch/jump redirect and trap/return sources.
- Handles stalls and wait-state memory. Sits between the fetch interface, the branch/jump unit and the trap logic of the RV32IM core.

---
 rtl/program_counter_ctrl_if.sv | 11 +
 rtl/program_counter_ctrl.sv | 179 +++++++++++++++++
 tb/tb_program_counter_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_counter_ctrl_if.sv
// Fetch handshake between the PC controller (master) and instruction memory (slave).
interface program_counter_ctrl_if #(
  parameter int DWIDTH = 32
) ();
  logic              fetch_req;
  logic [DWIDTH-1:0] fetch_addr;
  logic              fetch_gnt;

  modport master (output fetch_req, output fetch_addr, input fetch_gnt);
  modport slave  (input fetch_req, input fetch_addr, output fetch_gnt);
endinterface

// File: rtl/program_counter_ctrl.sv
// Program counter sequencer: fetch handshake, stall/hold, next-PC selection with a one-entry pending event.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirect/return targets divert to TRAP_VECTOR.
module program_counter_ctrl #(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DWIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  program_counter_ctrl_if.master fetch_if,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [DWIDTH-1:0]     redirect_target_i,
  input  logic                  trap_req_i,
  input  logic                  mret_req_i,
  input  logic [DWIDTH-1:0]     epc_in_i,
  output logic [DWIDTH-1:0]     program_count_curr_o,
  output logic [DWIDTH-1:0]     program_count_next_o,
  output logic                  pc_update_o,
  output logic                  misaligned_trap_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [1:0] PRIO_NONE  = 2'd0;
  localparam logic [1:0] PRIO_REDIR = 2'd1;
  localparam logic [1:0] PRIO_MRET  = 2'd2;
  localparam logic [1:0] PRIO_TRAP  = 2'd3;

  localparam logic [DWIDTH-1:0] PC_STEP    = {{(DWIDTH-3){1'b0}}, 3'b100};
  localparam logic [DWIDTH-1:0] ALIGN_MASK = {{(DWIDTH-2){1'b1}}, 2'b00};

  // Returns {misaligned_flag, target_to_load} for a software-supplied target.
  function automatic logic [DWIDTH:0] resolve_target(input logic [DWIDTH-1:0] addr);
`ifdef PC_MISALIGN_TRAP_EN
    if ((addr & ~ALIGN_MASK) != {DWIDTH{1'b0}}) begin
      resolve_target = {1'b1, TRAP_VECTOR};
    end else begin
      resolve_target = {1'b0, addr};
    end
`else
    resolve_target = {1'b0, addr & ALIGN_MASK};
`endif
  endfunction

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic              pc_update_q;
  logic              mis_q, mis_d;
  logic              fetch_req_q;
  logic [1:0]        pend_prio_q, pend_prio_d;
  logic [DWIDTH-1:0] pend_target_q, pend_target_d;
  logic              pend_mis_q, pend_mis_d;

  logic              update_s;
  logic [1:0]        ev_prio_s;
  logic [DWIDTH-1:0] ev_target_s;
  logic              ev_mis_s;
  logic [DWIDTH-1:0] pc_seq_s;

  assign pc_seq_s = pc_q + PC_STEP;

  // State transitions and identification of PC update points.
  always_comb begin
    state_d  = state_q;
    update_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_if.fetch_gnt) begin
          if (stall_i) begin
            state_d = ST_HOLD;
          end else begin
            update_s = 1'b1;
            state_d  = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          update_s = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Highest-priority event of this cycle, already resolved to its load target.
  always_comb begin
    ev_prio_s   = PRIO_NONE;
    ev_target_s = {DWIDTH{1'b0}};
    ev_mis_s    = 1'b0;
    if (trap_req_i) begin
      ev_prio_s   = PRIO_TRAP;
      ev_target_s = TRAP_VECTOR;
    end else if (mret_req_i) begin
      ev_prio_s                = PRIO_MRET;
      {ev_mis_s, ev_target_s}  = resolve_target(epc_in_i);
    end else if (redirect_valid_i) begin
      ev_prio_s                = PRIO_REDIR;
      {ev_mis_s, ev_target_s}  = resolve_target(redirect_target_i);
    end else begin
      ev_prio_s   = PRIO_NONE;
    end
  end

  // Next PC selection and pending-entry capture/consumption.
  always_comb begin
    pc_d          = pc_q;
    mis_d         = 1'b0;
    pend_prio_d   = pend_prio_q;
    pend_target_d = pend_target_q;
    pend_mis_d    = pend_mis_q;
    if (update_s) begin
      if (ev_prio_s != PRIO_NONE) begin
        pc_d  = ev_target_s;
        mis_d = ev_mis_s;
      end else if (pend_prio_q != PRIO_NONE) begin
        pc_d  = pend_target_q;
        mis_d = pend_mis_q;
      end else begin
        pc_d  = pc_seq_s;
      end
      pend_prio_d   = PRIO_NONE;
      pend_target_d = {DWIDTH{1'b0}};
      pend_mis_d    = 1'b0;
    end else if ((ev_prio_s != PRIO_NONE) && (ev_prio_s >= pend_prio_q)) begin
      pend_prio_d   = ev_prio_s;
      pend_target_d = ev_target_s;
      pend_mis_d    = ev_mis_s;
    end else begin
      pend_prio_d   = pend_prio_q;
    end
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      pc_update_q   <= 1'b0;
      mis_q         <= 1'b0;
      fetch_req_q   <= 1'b0;
      pend_prio_q   <= PRIO_NONE;
      pend_target_q <= {DWIDTH{1'b0}};
      pend_mis_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_update_q   <= update_s;
      mis_q         <= update_s & mis_d;
      fetch_req_q   <= (state_d == ST_FETCH);
      pend_prio_q   <= pend_prio_d;
      pend_target_q <= pend_target_d;
      pend_mis_q    <= pend_mis_d;
    end
  end

  assign fetch_if.fetch_req   = fetch_req_q;
  assign fetch_if.fetch_addr  = pc_q;
  assign program_count_curr_o = pc_q;
  assign program_count_next_o = pc_seq_s;
  assign pc_update_o          = pc_update_q;
  assign misaligned_trap_o    = mis_q;

endmodule

// File: tb/tb_program_counter_ctrl.sv
// Scoreboard bench: stimulus pushes expected loaded PCs; a monitor pops on every Pc_Update.
module tb_program_counter_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic        mret_req;
  logic [31:0] epc_in;
  logic [31:0] pc_curr;
  logic [31:0] pc_next;
  logic        pc_update;
  logic        mis_trap;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  program_counter_ctrl_if #(.DWIDTH(32)) fif ();

  program_counter_ctrl #(
    .DWIDTH       (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100)
  ) dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .fetch_if             (fif),
    .stall_i              (stall),
    .redirect_valid_i     (redirect_valid),
    .redirect_target_i    (redirect_target),
    .trap_req_i           (trap_req),
    .mret_req_i           (mret_req),
    .epc_in_i             (epc_in),
    .program_count_curr_o (pc_curr),
    .program_count_next_o (pc_next),
    .pc_update_o          (pc_update),
    .misaligned_trap_o    (mis_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic mis);
    exp_t e;
    e.pc  = pc;
    e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every PC load must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && pc_update) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_update: got pc 0x%08h expected no update", pc_curr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pc_load", pc_curr, e.pc);
        check("misaligned_trap", {31'd0, mis_trap}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    fif.fetch_gnt   = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0000_0000;
    trap_req        = 1'b0;
    mret_req        = 1'b0;
    epc_in          = 32'h0000_0000;
    push(32'h0000_0004, 1'b0);
    push(32'h0000_0008, 1'b0);
    push(32'h0000_000C, 1'b0);
    push(32'h0000_0010, 1'b0);

    repeat (2) @(negedge clk);
    check("reset_pc", pc_curr, 32'h0000_0000);
    check("reset_fetch_req", {31'd0, fif.fetch_req}, 32'd0);
    check("reset_pc_update", {31'd0, pc_update}, 32'd0);
    check("reset_mis", {31'd0, mis_trap}, 32'd0);
    rst_n = 1'b1;

    step();
    check("first_fetch_req", {31'd0, fif.fetch_req}, 32'd1);
    check("first_fetch_addr", fif.fetch_addr, 32'h0000_0000);
    repeat (4) step();
    check("addr_at_0x10", fif.fetch_addr, 32'h0000_0010);

    // Wait states: grant withheld for three cycles.
    fif.fetch_gnt = 1'b0;
    repeat (3) begin
      step();
      check("waitstate_addr", fif.fetch_addr, 32'h0000_0010);
      check("waitstate_req", {31'd0, fif.fetch_req}, 32'd1);
    end
    push(32'h0000_0014, 1'b0);
    push(32'h0000_0018, 1'b0);
    push(32'h0000_001C, 1'b0);
    push(32'h0000_0020, 1'b0);
    fif.fetch_gnt = 1'b1;
    repeat (4) step();

    // Stall after the grant at 0x20.
    stall = 1'b1;
    repeat (2) begin
      step();
      check("hold_req", {31'd0, fif.fetch_req}, 32'd0);
      check("hold_pc", pc_curr, 32'h0000_0020);
    end
    push(32'h0000_0024, 1'b0);
    stall = 1'b0;
    step();

    // Trap beats a simultaneous redirect.
    trap_req        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    push(32'h0000_0100, 1'b0);
    step();
    trap_req       = 1'b0;
    redirect_valid = 1'b0;
    push(32'h0000_0104, 1'b0);
    step();

    // Redirect while no grant becomes pending.
    fif.fetch_gnt   = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    check("pending_no_load", pc_curr, 32'h0000_0104);
    step();
    fif.fetch_gnt = 1'b1;
    push(32'h0000_0080, 1'b0);
    step();

    // Wrap-around.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    push(32'hFFFF_FFF8, 1'b0);
    step();
    redirect_valid = 1'b0;
    push(32'hFFFF_FFFC, 1'b0);
    push(32'h0000_0000, 1'b0);
    step();
    check("wrap_curr", pc_curr, 32'hFFFF_FFFC);
    check("wrap_next", pc_next, 32'h0000_0000);
    step();

    // Misaligned redirect target.
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0302;
`ifdef PC_MISALIGN_TRAP_EN
    push(32'h0000_0100, 1'b1);
`else
    push(32'h0000_0300, 1'b0);
`endif
    step();
    redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    push(32'h0000_0104, 1'b0);
`else
    push(32'h0000_0304, 1'b0);
`endif
    step();

    // Mret beats a simultaneous redirect.
    mret_req        = 1'b1;
    epc_in          = 32'h0000_0040;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0500;
    push(32'h0000_0040, 1'b0);
    step();
    mret_req = 1'b0;

    // Pending overwrite: redirect, then trap replaces it, then a lower redirect is ignored.
    fif.fetch_gnt   = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0600;
    step();
    redirect_valid = 1'b0;
    trap_req       = 1'b1;
    step();
    trap_req        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0700;
    step();
    redirect_valid = 1'b0;
    fif.fetch_gnt  = 1'b1;
    push(32'h0000_0100, 1'b0);
    step();
    fif.fetch_gnt = 1'b0;
    repeat (4) step();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
